// File: rtl/udp_gmii_send_if.sv
// udp_gmii_send_if: payload RAM read port plus GMII transmit pins.
// The master modport is the frame transmitter; the slave side is the RAM/PHY.
interface udp_gmii_send_if #(
    parameter int AW = 9
);
    logic [AW-1:0] ram_rd_addr;
    logic [31:0]   ram_rd_data;
    logic [7:0]    gmii_txd;
    logic          gmii_tx_en;

    modport master (
        output ram_rd_addr, gmii_txd, gmii_tx_en,
        input  ram_rd_data
    );
    modport slave (
        input  ram_rd_addr, gmii_txd, gmii_tx_en,
        output ram_rd_data
    );
endinterface

// File: rtl/udp_gmii_send.sv
// udp_gmii_send: GMII UDP/IPv4 frame transmitter fed from a 32-bit payload RAM.
// Define IP_CHECKSUM_EN to compute the IPv4 header checksum; otherwise it is sent as zero.
module udp_gmii_send #(
    parameter logic [47:0] BOARD_MAC  = 48'h000d1157283f,
    parameter logic [7:0]  IP_TTL     = 8'h80,
    parameter int          IFG_CYCLES = 12,
    parameter int          RAM_AW     = 9
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   tx_start,
    input  logic [47:0]            pc_mac,
    input  logic [31:0]            board_IP,
    input  logic [31:0]            pc_IP,
    input  logic [15:0]            src_port,
    input  logic [15:0]            dst_port,
    input  logic [15:0]            tx_data_length,
    udp_gmii_send_if.master        bus,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic [31:0]            send_counter
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_MAC, S_TYPE, S_IP,
        S_UDP, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t              state_q;
    logic [15:0]         cnt_q;
    logic [47:0]         mac_q;
    logic [31:0]         bip_q, pip_q;
    logic [15:0]         sp_q, dp_q, len_q, ident_q;
    logic [31:0]         crc_q, sent_q;
    logic [RAM_AW-1:0]   addr_q;
    logic [7:0]          txd_q;
    logic                en_q, busy_q, done_q;

    logic [15:0]  len_c, tot_len, udp_len, csum;
    logic [95:0]  mac_hdr;
    logic [159:0] ip_hdr;
    logic [63:0]  udp_hdr;
    logic [3:0]   mac_i;
    logic [4:0]   ip_i;
    logic [2:0]   udp_i;
    logic [1:0]   dat_i;
    logic [7:0]   byte_d, fcs_b;
    logic [31:0]  crc_nx;

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign len_c = (tx_data_length == 16'd0)    ? 16'd1 :
                   (tx_data_length > 16'd1472)  ? 16'd1472 : tx_data_length;
    assign tot_len = len_q + 16'd28;
    assign udp_len = len_q + 16'd8;

`ifdef IP_CHECKSUM_EN
    logic [19:0] sum20;
    logic [16:0] fold1;
    logic [15:0] csum_q;

    assign sum20 = 20'h04500 + 20'(tot_len) + 20'(ident_q) + 20'h04000
                 + 20'({IP_TTL, 8'h11})
                 + 20'(bip_q[31:16]) + 20'(bip_q[15:0])
                 + 20'(pip_q[31:16]) + 20'(pip_q[15:0]);
    assign fold1 = 17'(sum20[15:0]) + 17'(sum20[19:16]);

    // Header inputs are frozen at start, so the preamble gives the sum time to settle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            csum_q <= '0;
        else if (state_q == S_PRE)
            csum_q <= ~(fold1[15:0] + 16'(fold1[16]));
    end
    assign csum = csum_q;
`else
    assign csum = 16'h0000;
`endif

    assign mac_hdr = {mac_q, BOARD_MAC};
    assign ip_hdr  = {8'h45, 8'h00, tot_len, ident_q, 16'h4000,
                      IP_TTL, 8'h11, csum, bip_q, pip_q};
    assign udp_hdr = {sp_q, dp_q, udp_len, 16'h0000};
    assign mac_i   = 4'd11 - cnt_q[3:0];
    assign ip_i    = 5'd19 - cnt_q[4:0];
    assign udp_i   = 3'd7 - cnt_q[2:0];
    assign dat_i   = 2'd3 - cnt_q[1:0];
    assign fcs_b   = 8'(~crc_q >> {cnt_q[1:0], 3'b000});
    assign crc_nx  = crc8(crc_q, byte_d);

    always_comb begin
        byte_d = 8'h00;
        case (state_q)
            S_MAC:   byte_d = 8'(mac_hdr >> {mac_i, 3'b000});
            S_TYPE:  byte_d = (cnt_q == 16'd0) ? 8'h08 : 8'h00;
            S_IP:    byte_d = 8'(ip_hdr >> {ip_i, 3'b000});
            S_UDP:   byte_d = 8'(udp_hdr >> {udp_i, 3'b000});
            S_DATA:  byte_d = 8'(bus.ram_rd_data >> {dat_i, 3'b000});
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mac_q   <= '0;
            bip_q   <= '0;
            pip_q   <= '0;
            sp_q    <= '0;
            dp_q    <= '0;
            len_q   <= '0;
            ident_q <= '0;
            crc_q   <= '1;
            addr_q  <= '0;
            txd_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sent_q  <= '0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_q + 16'd1;
            if (state_q inside {S_MAC, S_TYPE, S_IP, S_UDP, S_DATA, S_PAD}) begin
                txd_q <= byte_d;
                crc_q <= crc_nx;
            end
            unique case (state_q)
                S_IDLE: begin
                    txd_q <= 8'h00;
                    en_q  <= 1'b0;
                    cnt_q <= '0;
                    if (tx_start) begin
                        mac_q   <= pc_mac;
                        bip_q   <= board_IP;
                        pip_q   <= pc_IP;
                        sp_q    <= src_port;
                        dp_q    <= dst_port;
                        len_q   <= len_c;
                        addr_q  <= '0;
                        crc_q   <= '1;
                        busy_q  <= 1'b1;
                        en_q    <= 1'b1;
                        txd_q   <= 8'h55;
                        cnt_q   <= 16'd1;
                        state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    txd_q <= (cnt_q == 16'd7) ? 8'hd5 : 8'h55;
                    if (cnt_q == 16'd7) begin
                        cnt_q   <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC:
                    if (cnt_q == 16'd11) begin
                        cnt_q   <= '0;
                        state_q <= S_TYPE;
                    end
                S_TYPE:
                    if (cnt_q == 16'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_IP;
                    end
                S_IP:
                    if (cnt_q == 16'd19) begin
                        cnt_q   <= '0;
                        state_q <= S_UDP;
                    end
                S_UDP:
                    if (cnt_q == 16'd7) begin
                        cnt_q   <= '0;
                        state_q <= S_DATA;
                    end
                S_DATA: begin
                    // Synchronous RAM: step the address two bytes before the word is needed.
                    if (cnt_q[1:0] == 2'd2 && (cnt_q + 16'd2) < len_q)
                        addr_q <= addr_q + RAM_AW'(1);
                    if (cnt_q == len_q - 16'd1) begin
                        cnt_q   <= '0;
                        state_q <= (len_q < 16'd18) ? S_PAD : S_FCS;
                    end
                end
                S_PAD:
                    if (cnt_q == 16'd17 - len_q) begin
                        cnt_q   <= '0;
                        state_q <= S_FCS;
                    end
                S_FCS: begin
                    txd_q <= fcs_b;
                    if (cnt_q == 16'd3) begin
                        cnt_q   <= '0;
                        state_q <= S_IFG;
                    end
                end
                S_IFG: begin
                    txd_q <= 8'h00;
                    en_q  <= 1'b0;
                    if (cnt_q == 16'(IFG_CYCLES - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        sent_q  <= sent_q + 32'd1;
                        ident_q <= ident_q + 16'd1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_rd_addr = addr_q;
    assign bus.gmii_txd    = txd_q;
    assign bus.gmii_tx_en  = en_q;
    assign tx_busy         = busy_q;
    assign tx_done         = done_q;
    assign send_counter    = sent_q;
endmodule
